pong_match_ctrl: RTL and testbench
==================================

# pong_match_ctrl

Match-level controller for the Pong game, sitting upstream of the ball and paddle movers and alongside the graphics renderer. Once per game tick it samples the ball position, detects goals, keeps both scores and sequences the idle/serve/play/point/game-over flow. It drives a freeze and serve handshake into the ball logic, and publishes scores and match status to the graphics block.

## Interface
Parameters:
- MAX_SCORE, 10, points needed to win; score width SW = $clog2(MAX_SCORE+1).
- GOAL_TOP_Y, 8, ball_y strictly below this is a goal against player 1 (top paddle).
- GOAL_BOTTOM_Y, 311, ball_y strictly above this is a goal against player 2 (bottom paddle).
- HOLD_TICKS, 50, game ticks spent in POINT before the next serve (1 s at 50 Hz).

Ports:
- clock  in  1  system clock, 50 MHz; one clock, all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- game_tick  in  1  single-cycle strobe in the clock domain, one per game frame.
- start  in  1  single-cycle start request, already synchronised and debounced.
- ball_x  in  8  ball column, 0..239.
- ball_y  in  9  ball row, 0..319.
- score_1  out  SW  player 1 score.
- score_2  out  SW  player 2 score.
- freeze  out  1  high means the ball and paddles must hold position.
- serve  out  1  single-cycle pulse that re-centres the ball and launches it.
- serve_dir  out  1  direction of the launch: 0 means toward player 1 (up), 1 means toward player 2 (down). Valid while serve is high.
- game_over  out  1  high in GAME_OVER.
- winner  out  1  0 means player 1 won, 1 means player 2 won. Valid while game_over is high.

## Operation
- States are IDLE, SERVE, PLAY, POINT and GAME_OVER.
- Reset values: state IDLE, both scores 0, freeze 1, serve 0, serve_dir 0, game_over 0, winner 0, hold counter 0.
- IDLE: freeze=1. When start=1, clear both scores and go to SERVE.
- SERVE: lasts exactly one clock.
  - serve=1 and freeze=0 during that clock.
  - serve_dir comes from the last_loser register: the ball is served toward the player who just conceded.
  - The next state is PLAY unconditionally.
- PLAY: freeze=0. Goal checks happen only on game_tick cycles.
  - If ball_y < GOAL_TOP_Y: score_2 increments and last_loser is set to 0.
  - Otherwise, if ball_y > GOAL_BOTTOM_Y: score_1 increments and last_loser is set to 1.
  - The top goal has priority over the bottom goal.
  - If the incremented score equals MAX_SCORE, go to GAME_OVER and set winner to the scorer. Otherwise go to POINT and clear the hold counter.
  - On a tick with no goal, stay in PLAY.
- POINT: freeze=1.
  - The hold counter increments on each game_tick.
  - When the counter reaches HOLD_TICKS-1 on a tick, go to SERVE.
- GAME_OVER: freeze=1, game_over=1, and the scores are held.
  - When start=1, clear both scores, clear game_over, and go to POINT with the hold counter cleared.
- start is ignored in SERVE, PLAY and POINT.
- Scores never exceed MAX_SCORE. Increments are saturating, as a guard.
- last_loser resets to 0, so the first serve after reset goes up.
- ball_x is not used for goal decisions. It is carried for future side-wall statistics only.

## Timing
- All outputs are registered.
- Score, state, game_over and winner update on the clock edge that samples the qualifying game_tick. They are visible the cycle after the tick.
- The serve pulse comes exactly 1 clock after the IDLE start or after the final POINT tick.
- Hold duration: from the scoring tick to the serve pulse is exactly HOLD_TICKS ticks plus 1 clock.
- start and game_tick in the same cycle while in IDLE or GAME_OVER: start wins. The tick has no effect in those states.
- Reset asserted mid-match forces the reset values immediately (asynchronously). Release is synchronous to the next clock edge.
- freeze is low only in SERVE and PLAY.

## Structure
- Shared package pong_pkg holds:
  - the match_state_t enum (IDLE, SERVE, PLAY, POINT, GAME_OVER);
  - default constants for LCD_WIDTH=240, LCD_HEIGHT=320, MAX_SCORE, the goal rows and HOLD_TICKS.
- Sub-module point_hold_timer: a tick-qualified counter with clear, enable and done outputs, parameterised by HOLD_TICKS.
- The FSM, the score registers and last_loser stay in pong_match_ctrl.

## Test plan
- Reset then start pulse → serve high for exactly 1 clock on the following cycle, serve_dir=0, freeze=0 afterwards, scores 0/0.
- PLAY, ball_y=5 on a tick → score_2=1, freeze=1 next cycle; after 50 further ticks, serve pulse with serve_dir=0.
- PLAY, ball_y=315 on a tick → score_1 increments and the next serve has serve_dir=1. Ball_y=5 or 315 without game_tick → no change.
- Score 9:0, ball_y=315 on a tick → score_1=10, game_over=1, winner=0, and no serve pulse even after 100 ticks.
- GAME_OVER, start and game_tick in the same cycle → scores 0/0, game_over=0, POINT entered; serve after 50 ticks.
- reset_n pulsed low in PLAY with score 4:3 → all outputs at reset values immediately; start required to resume.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong definitions: match FSM state encoding and default geometry /
// rule constants used by the match controller and its helpers.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } match_state_t;

    localparam int LCD_WIDTH         = 240;
    localparam int LCD_HEIGHT        = 320;
    localparam int DEF_MAX_SCORE     = 10;
    localparam int DEF_GOAL_TOP_Y    = 8;
    localparam int DEF_GOAL_BOTTOM_Y = 311;
    localparam int DEF_HOLD_TICKS    = 50;

endpackage

// File: rtl/point_hold_timer.sv
// Tick-qualified hold counter used while a point is being shown.
// Ports:
//   clock, reset_n : clock and async active-low reset
//   clear          : restart the count from 0 (wins over counting)
//   en             : count only while enabled
//   tick           : game tick strobe; one count per enabled tick
//   done           : high on the enabled tick that completes HOLD_TICKS ticks
module point_hold_timer
    import pong_pkg::*;
#(
    parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    input  logic tick,
    output logic done
);

    localparam int CW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_TICKS - 1);

    logic [CW-1:0] cnt_q;

    // Terminal count is combinational so the controller can move to SERVE on
    // the very edge that samples the final tick.
    assign done = en && tick && (cnt_q == LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (en && tick) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: samples the ball row once per game tick, detects
// goals, keeps both scores and sequences IDLE/SERVE/PLAY/POINT/GAME_OVER.
// Ports:
//   clock, reset_n   : clock and async active-low reset
//   game_tick        : one-cycle strobe per game frame
//   start            : one-cycle start request
//   ball_x, ball_y   : ball position (only ball_y drives goal decisions)
//   score_1, score_2 : player scores
//   freeze           : ball/paddles must hold position
//   serve, serve_dir : one-cycle launch pulse and its direction (0 up, 1 down)
//   game_over, winner: match finished and who won (0 player 1, 1 player 2)
// All outputs are registered.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int MAX_SCORE     = DEF_MAX_SCORE,
    parameter int GOAL_TOP_Y    = DEF_GOAL_TOP_Y,
    parameter int GOAL_BOTTOM_Y = DEF_GOAL_BOTTOM_Y,
    parameter int HOLD_TICKS    = DEF_HOLD_TICKS,
    localparam int SW           = $clog2(MAX_SCORE + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          game_tick,
    input  logic          start,
    input  logic [7:0]    ball_x,
    input  logic [8:0]    ball_y,
    output logic [SW-1:0] score_1,
    output logic [SW-1:0] score_2,
    output logic          freeze,
    output logic          serve,
    output logic          serve_dir,
    output logic          game_over,
    output logic          winner
);

    localparam logic [8:0]    TOP_Y    = 9'(GOAL_TOP_Y);
    localparam logic [8:0]    BOTTOM_Y = 9'(GOAL_BOTTOM_Y);
    localparam logic [SW-1:0] WIN_SC   = SW'(MAX_SCORE);

    // ball_x is carried for future side-wall statistics only.
    logic unused_ball_x;
    assign unused_ball_x = ^ball_x;

    match_state_t  state_q, state_d;
    logic [SW-1:0] score_1_d, score_2_d;
    logic          last_loser_q, last_loser_d;
    logic          winner_d;
    logic          tmr_clear, tmr_en, tmr_done;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] s);
        return (s < WIN_SC) ? s + 1'b1 : s;
    endfunction

    point_hold_timer #(
        .HOLD_TICKS(HOLD_TICKS)
    ) u_hold (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (tmr_clear),
        .en     (tmr_en),
        .tick   (game_tick),
        .done   (tmr_done)
    );

    always_comb begin
        state_d      = state_q;
        score_1_d    = score_1;
        score_2_d    = score_2;
        last_loser_d = last_loser_q;
        winner_d     = winner;
        tmr_clear    = 1'b0;
        tmr_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    score_1_d = '0;
                    score_2_d = '0;
                    state_d   = SERVE;
                end
            end
            SERVE: begin
                state_d = PLAY;
            end
            PLAY: begin
                if (game_tick) begin
                    // Top goal is checked first so it takes priority.
                    if (ball_y < TOP_Y) begin
                        score_2_d    = sat_inc(score_2);
                        last_loser_d = 1'b0;
                        if (score_2_d == WIN_SC) begin
                            state_d  = GAME_OVER;
                            winner_d = 1'b1;
                        end else begin
                            state_d   = POINT;
                            tmr_clear = 1'b1;
                        end
                    end else if (ball_y > BOTTOM_Y) begin
                        score_1_d    = sat_inc(score_1);
                        last_loser_d = 1'b1;
                        if (score_1_d == WIN_SC) begin
                            state_d  = GAME_OVER;
                            winner_d = 1'b0;
                        end else begin
                            state_d   = POINT;
                            tmr_clear = 1'b1;
                        end
                    end
                end
            end
            POINT: begin
                tmr_en = 1'b1;
                if (tmr_done) state_d = SERVE;
            end
            GAME_OVER: begin
                // Rematch goes through a full hold before the first serve.
                if (start) begin
                    score_1_d = '0;
                    score_2_d = '0;
                    state_d   = POINT;
                    tmr_clear = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state
    // register instead of trailing it by a cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            score_1      <= '0;
            score_2      <= '0;
            last_loser_q <= 1'b0;
            winner       <= 1'b0;
            freeze       <= 1'b1;
            serve        <= 1'b0;
            serve_dir    <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_1      <= score_1_d;
            score_2      <= score_2_d;
            last_loser_q <= last_loser_d;
            winner       <= winner_d;
            freeze       <= !((state_d == SERVE) || (state_d == PLAY));
            serve        <= (state_d == SERVE);
            serve_dir    <= last_loser_d;
            game_over    <= (state_d == GAME_OVER);
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed self-checking bench for pong_match_ctrl with default parameters.
module tb_pong_match_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       game_tick = 1'b0;
    logic       start = 1'b0;
    logic [7:0] ball_x = 8'd120;
    logic [8:0] ball_y = 9'd160;
    logic [3:0] score_1, score_2;
    logic       freeze, serve, serve_dir, game_over, winner;

    int ntests = 0;
    int nfails = 0;
    int serve_cnt = 0;

    always #5 clock = ~clock;

    pong_match_ctrl dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .game_tick(game_tick),
        .start    (start),
        .ball_x   (ball_x),
        .ball_y   (ball_y),
        .score_1  (score_1),
        .score_2  (score_2),
        .freeze   (freeze),
        .serve    (serve),
        .serve_dir(serve_dir),
        .game_over(game_over),
        .winner   (winner)
    );

    // One clock with the given inputs; outputs sampled 1 ns after the edge.
    task automatic do_cycle(input logic gt, input logic st, input int y);
        game_tick = gt;
        start     = st;
        ball_y    = 9'(y);
        @(posedge clock);
        #1;
        game_tick = 1'b0;
        start     = 1'b0;
        if (serve === 1'b1) serve_cnt++;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b0, 160);
    endtask

    // From SERVE or PLAY: settle into PLAY, score at row y, wait out the hold.
    task automatic play_goal(input int y);
        do_cycle(1'b0, 1'b0, 160);
        do_cycle(1'b1, 1'b0, y);
        hold(50);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        ntests++;
        if ({score_1, score_2} !== 8'h00) begin
            $display("FAIL reset_scores: got %0d/%0d want 0/0", score_1, score_2); nfails++;
        end
        ntests++;
        if ({freeze, serve, serve_dir, game_over, winner} !== 5'b10000) begin
            $display("FAIL reset_flags: got f%b s%b d%b g%b w%b want f1 s0 d0 g0 w0",
                     freeze, serve, serve_dir, game_over, winner); nfails++;
        end
        #3 reset_n = 1'b1;
        // Tick in IDLE does nothing.
        do_cycle(1'b1, 1'b0, 5);
        ntests++;
        if (score_2 !== 4'd0 || freeze !== 1'b1 || serve !== 1'b0) begin
            $display("FAIL idle_tick: got s2=%0d f%b s%b want 0 f1 s0", score_2, freeze, serve); nfails++;
        end
    endtask

    task automatic test_start_serve;
        do_cycle(1'b0, 1'b1, 160);
        ntests++;
        if (serve !== 1'b1 || serve_dir !== 1'b0 || freeze !== 1'b0) begin
            $display("FAIL first_serve: got s%b d%b f%b want s1 d0 f0", serve, serve_dir, freeze); nfails++;
        end
        do_cycle(1'b0, 1'b0, 160);
        ntests++;
        if (serve !== 1'b0 || freeze !== 1'b0 || {score_1, score_2} !== 8'h00) begin
            $display("FAIL serve_one_clock: got s%b f%b sc=%0d/%0d want s0 f0 0/0",
                     serve, freeze, score_1, score_2); nfails++;
        end
    endtask

    task automatic test_goal_top;
        int base;
        do_cycle(1'b1, 1'b0, 8);    // boundary row, not a goal
        do_cycle(1'b1, 1'b0, 311);  // boundary row, not a goal
        ntests++;
        if ({score_1, score_2} !== 8'h00 || freeze !== 1'b0) begin
            $display("FAIL goal_boundary: got %0d/%0d f%b want 0/0 f0", score_1, score_2, freeze); nfails++;
        end
        do_cycle(1'b1, 1'b0, 5);
        ntests++;
        if (score_2 !== 4'd1 || score_1 !== 4'd0 || freeze !== 1'b1) begin
            $display("FAIL top_goal: got %0d/%0d f%b want 0/1 f1", score_1, score_2, freeze); nfails++;
        end
        base = serve_cnt;
        for (int i = 0; i < 49; i++) begin
            do_cycle(1'b1, 1'b1, 160);  // start ignored in POINT
            do_cycle(1'b0, 1'b0, 160);
        end
        ntests++;
        if (serve_cnt !== base || freeze !== 1'b1) begin
            $display("FAIL hold_49: got serves=%0d f%b want 0 f1", serve_cnt - base, freeze); nfails++;
        end
        do_cycle(1'b1, 1'b0, 160);
        ntests++;
        if (serve !== 1'b1 || serve_dir !== 1'b0 || freeze !== 1'b0) begin
            $display("FAIL hold_serve: got s%b d%b f%b want s1 d0 f0", serve, serve_dir, freeze); nfails++;
        end
    endtask

    task automatic test_goal_bottom;
        do_cycle(1'b0, 1'b0, 160);
        do_cycle(1'b0, 1'b0, 315);
        do_cycle(1'b0, 1'b0, 5);
        do_cycle(1'b0, 1'b1, 160);  // start ignored in PLAY
        ntests++;
        if (score_1 !== 4'd0 || score_2 !== 4'd1 || freeze !== 1'b0 || serve !== 1'b0) begin
            $display("FAIL no_tick_no_goal: got %0d/%0d f%b s%b want 0/1 f0 s0",
                     score_1, score_2, freeze, serve); nfails++;
        end
        do_cycle(1'b1, 1'b0, 315);
        ntests++;
        if (score_1 !== 4'd1 || score_2 !== 4'd1 || freeze !== 1'b1) begin
            $display("FAIL bottom_goal: got %0d/%0d f%b want 1/1 f1", score_1, score_2, freeze); nfails++;
        end
        hold(50);
        ntests++;
        if (serve !== 1'b1 || serve_dir !== 1'b1) begin
            $display("FAIL serve_down: got s%b d%b want s1 d1", serve, serve_dir); nfails++;
        end
    endtask

    task automatic test_game_over;
        int base;
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        do_cycle(1'b0, 1'b1, 160);
        for (int k = 0; k < 9; k++) play_goal(312);
        ntests++;
        if (score_1 !== 4'd9 || score_2 !== 4'd0 || serve !== 1'b1) begin
            $display("FAIL nine_nil: got %0d/%0d s%b want 9/0 s1", score_1, score_2, serve); nfails++;
        end
        do_cycle(1'b0, 1'b0, 160);
        do_cycle(1'b1, 1'b0, 315);
        ntests++;
        if (score_1 !== 4'd10 || game_over !== 1'b1 || winner !== 1'b0 || freeze !== 1'b1) begin
            $display("FAIL win: got s1=%0d g%b w%b f%b want 10 g1 w0 f1",
                     score_1, game_over, winner, freeze); nfails++;
        end
        base = serve_cnt;
        for (int i = 0; i < 100; i++) do_cycle(1'b1, 1'b0, 315);
        ntests++;
        if (serve_cnt !== base || game_over !== 1'b1 || score_1 !== 4'd10 || score_2 !== 4'd0) begin
            $display("FAIL over_hold: got serves=%0d g%b %0d/%0d want 0 g1 10/0",
                     serve_cnt - base, game_over, score_1, score_2); nfails++;
        end
    endtask

    task automatic test_restart;
        int base;
        do_cycle(1'b1, 1'b1, 5);  // start and tick together: start wins
        ntests++;
        if ({score_1, score_2} !== 8'h00 || game_over !== 1'b0 || freeze !== 1'b1 || serve !== 1'b0) begin
            $display("FAIL restart: got %0d/%0d g%b f%b s%b want 0/0 g0 f1 s0",
                     score_1, score_2, game_over, freeze, serve); nfails++;
        end
        base = serve_cnt;
        hold(49);
        ntests++;
        if (serve_cnt !== base) begin
            $display("FAIL restart_hold: got serves=%0d want 0", serve_cnt - base); nfails++;
        end
        do_cycle(1'b1, 1'b0, 160);
        ntests++;
        if (serve !== 1'b1 || serve_dir !== 1'b1) begin
            $display("FAIL restart_serve: got s%b d%b want s1 d1", serve, serve_dir); nfails++;
        end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 4; k++) play_goal(312);
        for (int k = 0; k < 3; k++) play_goal(7);
        do_cycle(1'b0, 1'b0, 160);
        ntests++;
        if (score_1 !== 4'd4 || score_2 !== 4'd3 || freeze !== 1'b0) begin
            $display("FAIL score_4_3: got %0d/%0d f%b want 4/3 f0", score_1, score_2, freeze); nfails++;
        end
        #2 reset_n = 1'b0;
        #1;
        ntests++;
        if ({score_1, score_2} !== 8'h00 || {freeze, serve, serve_dir, game_over, winner} !== 5'b10000) begin
            $display("FAIL async_reset: got %0d/%0d f%b s%b d%b g%b w%b want 0/0 f1 s0 d0 g0 w0",
                     score_1, score_2, freeze, serve, serve_dir, game_over, winner); nfails++;
        end
        #2 reset_n = 1'b1;
        do_cycle(1'b1, 1'b0, 5);
        do_cycle(1'b1, 1'b0, 315);
        ntests++;
        if ({score_1, score_2} !== 8'h00 || freeze !== 1'b1 || serve !== 1'b0) begin
            $display("FAIL post_reset_idle: got %0d/%0d f%b s%b want 0/0 f1 s0",
                     score_1, score_2, freeze, serve); nfails++;
        end
        do_cycle(1'b0, 1'b1, 160);
        ntests++;
        if (serve !== 1'b1 || serve_dir !== 1'b0) begin
            $display("FAIL resume_serve: got s%b d%b want s1 d0", serve, serve_dir); nfails++;
        end
    endtask

    initial begin
        test_reset();
        test_start_serve();
        test_goal_top();
        test_goal_bottom();
        test_game_over();
        test_restart();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfails);
        $finish;
    end

endmodule
